// File: rtl/dm_frame_rx.sv
// Framing stage for the FSK demodulator: hunts for a sync byte, assembles a
// 16-bit MSB-first word plus even parity, and flags parity and inter-bit timeouts.
module dm_frame_rx #(
    parameter logic [7:0]  SYNC_WORD = 8'h7E,
    parameter int unsigned TIMEOUT   = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bitin,
    input  logic        bitsinc,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        parity_err,
    output logic        timeout_err,
    output logic        in_frame,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  sync_sr;
    logic [3:0]  fill;
    logic [15:0] data_sr;
    logic [3:0]  bit_cnt;
    logic [15:0] tmo_cnt;

    logic [7:0]  sync_shifted;
    logic        sync_hit;
    logic        tmo_hit;
    logic        parity_bad;

    assign sync_shifted = {sync_sr[6:0], bitin};
    assign sync_hit     = bitsinc && (fill >= 4'd7) && (sync_shifted == SYNC_WORD);
    // A strobe in the same cycle as the terminal count always wins.
    assign tmo_hit      = (state != HUNT) && !bitsinc && (tmo_cnt == TMO_LAST);
    assign parity_bad   = ^{data_sr, bitin};

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT: begin
                if (sync_hit) state_nxt = DATA;
            end
            DATA: begin
                if (bitsinc && bit_cnt == 4'd15) state_nxt = PARITY;
                else if (tmo_hit)                state_nxt = HUNT;
            end
            PARITY: begin
                if (bitsinc || tmo_hit) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_sr     <= '0;
            fill        <= '0;
            data_sr     <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            word        <= '0;
            word_valid  <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            in_frame    <= 1'b0;
            frame_count <= '0;
        end else begin
            word_valid  <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= tmo_hit;
            in_frame    <= (state_nxt != HUNT);

            if (bitsinc)               tmo_cnt <= '0;
            else if (tmo_cnt != '1)    tmo_cnt <= tmo_cnt + 16'd1;

            unique case (state)
                HUNT: begin
                    if (bitsinc) begin
                        sync_sr <= sync_shifted;
                        if (sync_hit) begin
                            fill    <= '0;
                            bit_cnt <= '0;
                        end else if (fill != 4'd8) begin
                            fill <= fill + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (bitsinc) begin
                        data_sr <= {data_sr[14:0], bitin};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (tmo_hit) begin
                        sync_sr <= '0;
                        fill    <= '0;
                    end
                end
                PARITY: begin
                    if (bitsinc) begin
                        if (!parity_bad) begin
                            word        <= data_sr;
                            word_valid  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            parity_err  <= 1'b1;
                        end
                        sync_sr <= '0;
                        fill    <= '0;
                    end else if (tmo_hit) begin
                        sync_sr <= '0;
                        fill    <= '0;
                    end
                end
                default: begin
                    sync_sr <= '0;
                    fill    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_frame_rx.sv
// Scoreboard bench for dm_frame_rx: stimulus pushes expected pulses, a
// negedge monitor pops and compares them whenever the DUT pulses an output.
module tb_dm_frame_rx;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bitin = 1'b0;
    logic        bitsinc = 1'b0;
    logic [15:0] word;
    logic        word_valid, parity_err, timeout_err, in_frame;
    logic [7:0]  frame_count;

    dm_frame_rx #(.SYNC_WORD(8'h7E), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bitin(bitin), .bitsinc(bitsinc),
        .word(word), .word_valid(word_valid), .parity_err(parity_err),
        .timeout_err(timeout_err), .in_frame(in_frame), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 good word, 1 parity error, 2 timeout
    typedef struct {
        int          kind;
        logic [15:0] w;
        logic [7:0]  fc;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] m_word = '0;
    logic [7:0]  m_count = '0;
    int          last_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (word_valid || parity_err || timeout_err)) begin
            exp_t e;
            int   kind_act;
            kind_act = word_valid ? 0 : (parity_err ? 1 : 2);
            check("pulse_exclusive", {31'd0, word_valid & parity_err}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d with no expected event (cycle %0d)",
                         kind_act, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", kind_act, e.kind);
                check("pulse_cycle", cyc, e.at);
                check("word", {16'd0, word}, {16'd0, e.w});
                check("frame_count", {24'd0, frame_count}, {24'd0, e.fc});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the strobe is sampled at the following posedge.
    task automatic strobe(input logic b);
        bitin    = b;
        bitsinc  = 1'b1;
        last_cyc = cyc + 1;
        @(negedge clk);
        bitsinc  = 1'b0;
        bitin    = ~b;
    endtask

    task automatic send_sync(input int sp);
        logic [7:0] s;
        s = 8'h7E;
        for (int i = 7; i >= 0; i--) begin
            strobe(s[i]);
            if (i == 0) check("in_frame_rise", {31'd0, in_frame}, 32'd1);
            idle(sp - 1);
        end
    endtask

    // g1/g2 override the gap after data bits 4 and 9 when nonzero.
    task automatic send_frame(input logic [15:0] d, input logic p, input int sp,
                              input bit good, input int g1, input int g2);
        send_sync(sp);
        for (int j = 0; j < 16; j++) begin
            strobe(d[15 - j]);
            if (j == 4 && g1 != 0)      idle(g1 - 1);
            else if (j == 9 && g2 != 0) idle(g2 - 1);
            else                        idle(sp - 1);
        end
        if (good) begin
            m_word  = d;
            m_count = m_count + 8'd1;
        end
        sb.push_back('{good ? 0 : 1, m_word, m_count, cyc + 1});
        strobe(p);
        check("in_frame_fall", {31'd0, in_frame}, 32'd0);
        idle(sp - 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word"}, {16'd0, word}, 32'd0);
        check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        check({tag, "_in_frame"}, {31'd0, in_frame}, 32'd0);
        check({tag, "_frame_count"}, {24'd0, frame_count}, 32'd0);
    endtask

    initial begin
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Parity error first: word and count must stay at their reset values.
        send_frame(16'hA5C3, 1'b1, 30, 1'b0, 0, 0);
        // Good frame: A5C3 has eight ones, so parity bit 0.
        send_frame(16'hA5C3, 1'b0, 30, 1'b1, 0, 0);

        // Sliding sync after garbage, then two back-to-back frames at one bit per clock.
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        send_frame(16'h0001, 1'b1, 1, 1'b1, 0, 0);
        send_frame(16'hFFFF, 1'b0, 1, 1'b1, 0, 0);
        check("count_after_b2b", {24'd0, frame_count}, 32'd3);

        // Timeout after five data bits.
        send_sync(30);
        for (int j = 0; j < 5; j++) begin
            strobe(1'b1);
            if (j < 4) idle(29);
        end
        sb.push_back('{2, m_word, m_count, last_cyc + TMO});
        idle(TMO + 5);
        check("in_frame_after_timeout", {31'd0, in_frame}, 32'd0);
        // 1234 has five ones, so parity bit 1.
        send_frame(16'h1234, 1'b1, 2, 1'b1, 0, 0);

        // Strobes TMO-1 and exactly TMO clocks apart: neither may time out.
        // BEEF has thirteen ones, so parity bit 1.
        send_frame(16'hBEEF, 1'b1, 4, 1'b1, TMO - 1, TMO);

        // Asynchronous reset during the 8th data bit.
        send_sync(2);
        for (int j = 0; j < 7; j++) begin
            strobe(1'b1);
            idle(1);
        end
        check("in_frame_before_reset", {31'd0, in_frame}, 32'd1);
        bitin   = 1'b1;
        bitsinc = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        bitsinc = 1'b0;
        idle(2);
        rst     = 1'b0;
        m_word  = '0;
        m_count = '0;
        idle(2);
        // 00FF has eight ones, so parity bit 0.
        send_frame(16'h00FF, 1'b0, 3, 1'b1, 0, 0);

        idle(TMO + 10);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("final_frame_count", {24'd0, frame_count}, 32'd1);
        check("final_word", {16'd0, word}, 32'h00FF);
        check("final_in_frame", {31'd0, in_frame}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_frame_rx.md
# dm_frame_rx

Downstream framing stage for the FSK demodulator. It consumes the demodulated bit stream (`bitin`) and its one-cycle bit strobe (`bitsinc`). It hunts for an 8-bit sync pattern, then assembles a 16-bit data word (MSB first) followed by one even-parity bit. Good words are presented with a one-cycle valid pulse; parity failures and inter-bit timeouts are flagged and the block returns to sync hunting.

## Interface
- `SYNC_WORD`, default 8'h7E: sync pattern; the first received bit is the MSB.
- `TIMEOUT`, default 2000: maximum clocks allowed between strobes inside a frame. Range 2..65535.
- `clk`  in  1  sample clock, shared with the demodulator.
- `rst`  in  1  reset, asynchronous, active-high.
- `bitin`  in  1  demodulated bit; sampled only in cycles where `bitsinc`=1.
- `bitsinc`  in  1  one-cycle strobe marking a new demodulated bit.
- `word`  out  16  last good data word; holds its value between frames.
- `word_valid`  out  1  one-cycle pulse; `word` is new in this cycle.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch.
- `timeout_err`  out  1  one-cycle pulse when an in-frame timeout occurs.
- `in_frame`  out  1  high in states DATA and PARITY.
- `frame_count`  out  8  count of good frames; wraps 255 -> 0.

## Operation
- FSM states are HUNT, DATA and PARITY. Reset state is HUNT.
- HUNT:
  - On each strobe, `sync_sr <= {sync_sr[6:0], bitin}`. The fill counter increments and saturates at 8.
  - The match test uses the post-shift value: `{sync_sr[6:0], bitin} == SYNC_WORD` with fill >= 7 before the shift.
  - On a match: go to DATA, clear `bit_cnt`, and clear the fill counter. Overlapping matches are allowed, so hunting is a sliding window.
- DATA:
  - On each strobe, `data_sr <= {data_sr[14:0], bitin}` and `bit_cnt` increments.
  - On the strobe carrying the 16th bit (`bit_cnt`==15), go to PARITY.
- PARITY: on the strobe, compute `^{data_sr, bitin}`.
  - Result 0: `word <= data_sr`, pulse `word_valid`, increment `frame_count`.
  - Result 1: pulse `parity_err`; `word` is unchanged.
  - In both cases go to HUNT with `sync_sr` and the fill counter cleared. A new sync therefore needs 8 fresh bits.
- Timeout counter (16 bit):
  - Cleared on every strobe and on entry to DATA; otherwise increments, saturating.
  - In DATA or PARITY, reaching TIMEOUT-1 with no strobe in that cycle causes: pulse `timeout_err`, go to HUNT, clear `sync_sr` and fill.
  - In HUNT the counter runs but has no effect.
- Simultaneous strobe and timeout in the same cycle: the strobe wins. The bit is accepted and no error is raised.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous). Partial data is discarded.

## Timing
- Reset values:
  - `word`=0, `word_valid`=0, `parity_err`=0, `timeout_err`=0, `in_frame`=0, `frame_count`=0.
  - Internal: state HUNT, all counters and shift registers 0.
- All outputs are registered.
- `word_valid`, `parity_err` and `frame_count` update at the clock edge that samples the parity strobe. They are visible in the following cycle; latency is 1 clock.
- `word_valid` and `parity_err` are high for exactly 1 cycle and never high together.
- `in_frame`:
  - Rises in the cycle after the edge that samples the last sync bit.
  - Falls in the cycle after the parity strobe or the timeout.
- `timeout_err` is asserted 1 cycle after the counter reaches TIMEOUT-1, i.e. TIMEOUT clocks after the last strobe.
- Strobes may be back-to-back (every clock). No minimum spacing is required.
- `bitin` is ignored whenever `bitsinc`=0.

## Test plan
- Good frame: strobe the bits 01111110, 1010010111000011, 0, spaced 30 clocks apart.
  - Expect `word`=16'hA5C3, a single-cycle `word_valid`, `frame_count`=1, and `in_frame` low afterwards.
- Parity error: same frame with parity bit 1.
  - Expect a `parity_err` pulse, no `word_valid`, `word` still 0, `frame_count` still 0.
- Sliding sync plus back-to-back frames: send garbage 1,1,0, then frame A (16'h0001, parity 1), then immediately frame B (16'hFFFF, parity 0).
  - Expect two `word_valid` pulses with `word` equal to 16'h0001, then 16'hFFFF, and `frame_count`=2.
- Timeout: send sync, then 5 data bits, then no strobes.
  - Expect a `timeout_err` pulse exactly TIMEOUT clocks after the 5th strobe, then `in_frame`=0.
  - A following complete good frame is then received correctly.
- Strobe at the timeout boundary: in DATA, issue a strobe exactly TIMEOUT-1 clocks after the previous one.
  - Expect no `timeout_err`, and the frame completes normally.
- Reset mid-frame: assert `rst` during the 8th data bit.
  - Expect all outputs at reset values immediately, even with no clock edge.
  - After release, a complete good frame yields `frame_count`=1.
